note_sequencer: RTL and testbench

//  Step sequencer that drives one square-wave oscillator voice (ena / pitch_ticks / phase reset).
//  It holds a STEPS-entry note table and plays entries 0..last_step in order, each for a

---
 rtl/synth_pkg.sv | 24 ++
 rtl/note_sequencer_if.sv | 38 +++
 rtl/beat_prescaler.sv | 27 ++
 rtl/note_sequencer.sv | 118 +++++++++++
 tb/tb_note_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and sizes for the synth voice path: note-table entry layout and sequencer states.
package synth_pkg;

   localparam int N       = 8;
   localparam int STEPS   = 16;
   localparam int DUR_W   = 8;
   localparam int TEMPO_W = 16;
   localparam int AW      = $clog2(STEPS);

   typedef struct packed {
      logic             rest;
      logic [N-1:0]     pitch;
      logic [DUR_W-1:0] dur;
   } step_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2
   } seq_state_t;

   localparam step_t STEP_RESET = '{rest: 1'b1, pitch: '0, dur: '0};

endpackage

// File: rtl/note_sequencer_if.sv
// Control-side and oscillator-side signals of the note sequencer, bundled for port lists.
interface note_sequencer_if;
   import synth_pkg::*;

   // There is no valid/ready backpressure here: wr_en, start and stop are single-cycle
   // strobes sampled on the rising clock edge and always accepted; every output is registered.
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [N-1:0]       wr_pitch;
   logic [DUR_W-1:0]   wr_dur;
   logic               wr_rest;
   logic [TEMPO_W-1:0] tempo_ticks;
   logic [AW-1:0]      last_step;
   logic               loop_en;
   logic               start;
   logic               stop;

   logic               osc_ena;
   logic [N-1:0]       osc_pitch_ticks;
   logic               osc_rst;
   logic [AW-1:0]      step_idx;
   logic               busy;
   logic               done;
   seq_state_t         state_dbg;

   modport master (
      output wr_en, wr_addr, wr_pitch, wr_dur, wr_rest, tempo_ticks, last_step, loop_en,
             start, stop,
      input  osc_ena, osc_pitch_ticks, osc_rst, step_idx, busy, done, state_dbg
   );

   modport slave (
      input  wr_en, wr_addr, wr_pitch, wr_dur, wr_rest, tempo_ticks, last_step, loop_en,
             start, stop,
      output osc_ena, osc_pitch_ticks, osc_rst, step_idx, busy, done, state_dbg
   );

endinterface

// File: rtl/beat_prescaler.sv
// Beat prescaler: counts 0..period and flags the last count; a lowered period that the
// counter has already passed takes effect only after the counter wraps through its maximum.
module beat_prescaler
   import synth_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [TEMPO_W-1:0] period,
   output logic               tick
);

   logic [TEMPO_W-1:0] cnt;

   assign tick = (cnt == period);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TEMPO_W'(1);
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer for one square-wave voice: plays note-table entries 0..last_step, each for
// a programmed number of beats, optionally looping.
module note_sequencer
   import synth_pkg::*;
(
   input logic              clk,
   input logic              rst,
   note_sequencer_if.slave  bus
);

   step_t            table_q [STEPS];
   step_t            rd;
   seq_state_t       state;
   logic [AW-1:0]    step_q;
   logic [AW-1:0]    last_q;
   logic [DUR_W-1:0] beat_cnt;
   logic [DUR_W-1:0] cur_dur;
   logic [N-1:0]     pitch_q;
   logic             ena_q;
   logic             orst_q;
   logic             busy_q;
   logic             done_q;
   logic             beat;

   assign rd = table_q[step_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STEPS; i++) table_q[i] <= STEP_RESET;
      end else if (bus.wr_en) begin
         table_q[bus.wr_addr] <= '{rest: bus.wr_rest, pitch: bus.wr_pitch, dur: bus.wr_dur};
      end
   end

   // Held clear outside PLAY so every note starts on a fresh beat boundary.
   beat_prescaler u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != PLAY),
      .period (bus.tempo_ticks),
      .tick   (beat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         step_q   <= '0;
         last_q   <= '0;
         beat_cnt <= '0;
         cur_dur  <= '0;
         pitch_q  <= '0;
         ena_q    <= 1'b0;
         orst_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         orst_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  state  <= LOAD;
                  step_q <= '0;
                  last_q <= bus.last_step;
                  busy_q <= 1'b1;
               end
            end
            LOAD, PLAY: begin
               // stop outranks restart, which outranks the natural note end.
               if (bus.stop) begin
                  state  <= IDLE;
                  ena_q  <= 1'b0;
                  busy_q <= 1'b0;
               end else if (bus.start) begin
                  state  <= LOAD;
                  step_q <= '0;
                  last_q <= bus.last_step;
                  ena_q  <= 1'b0;
               end else if (state == LOAD) begin
                  state    <= PLAY;
                  pitch_q  <= rd.pitch;
                  ena_q    <= ~rd.rest;
                  orst_q   <= 1'b1;
                  cur_dur  <= rd.dur;
                  beat_cnt <= '0;
               end else if (beat) begin
                  if (beat_cnt == cur_dur) begin
                     ena_q <= 1'b0;
                     if (step_q != last_q) begin
                        step_q <= step_q + AW'(1);
                        state  <= LOAD;
                     end else if (bus.loop_en) begin
                        step_q <= '0;
                        state  <= LOAD;
                     end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + DUR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.osc_ena         = ena_q;
   assign bus.osc_pitch_ticks = pitch_q;
   assign bus.osc_rst         = orst_q;
   assign bus.step_idx        = step_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.state_dbg       = state;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: single-note vector table plus multi-step sequences,
// with a note-start scoreboard fed by the stimulus side.
module tb_note_sequencer;
   import synth_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   note_sequencer_if bus ();
   note_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [AW-1:0] step;
      logic [N-1:0]  pitch;
      logic          ena;
   } note_t;
   localparam int NW = AW + N + 1;

   typedef struct {
      int pitch;
      int dur;
      int rest;
      int tempo;
      int exp_lat;
      int exp_ena;
   } vec_t;

   logic [NW-1:0] exp_q[$];
   int n_vec   = 0;
   int n_err   = 0;
   int n_notes = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_note(input int step, input int pitch, input int rest);
      note_t n;
      n.step  = AW'(step);
      n.pitch = N'(pitch);
      n.ena   = (rest == 0);
      exp_q.push_back(n);
   endtask

   // Scoreboard: every osc_rst marks a note start and must match the next expected note.
   always @(negedge clk) begin
      if (!rst && bus.osc_rst) begin
         n_notes++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_note: got step %0d pitch %0d, expected no note",
                     bus.step_idx, bus.osc_pitch_ticks);
         end else begin
            note_t e;
            e = note_t'(exp_q.pop_front());
            check("note_step", int'(bus.step_idx), int'(e.step));
            check("note_pitch", int'(bus.osc_pitch_ticks), int'(e.pitch));
            check("note_ena", int'(bus.osc_ena), int'(e.ena));
         end
      end
   end

   task automatic wr(input int addr, input int pitch, input int dur, input int rest);
      @(negedge clk);
      bus.wr_en    = 1'b1;
      bus.wr_addr  = AW'(addr);
      bus.wr_pitch = N'(pitch);
      bus.wr_dur   = DUR_W'(dur);
      bus.wr_rest  = (rest != 0);
      @(negedge clk);
      bus.wr_en    = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts edges after the start edge until done; optionally clears loop_en or rewrites
   // step 0 to pitch 99 after a given edge count.
   task automatic wait_done(input int max, input int clr_loop_at, input int wr_at,
                            output int lat, output int ena_cnt);
      bit got = 0;
      lat = 0;
      ena_cnt = 0;
      for (int c = 0; c < max; c++) begin
         @(posedge clk);
         #1;
         lat++;
         bus.wr_en = 1'b0;
         if (bus.osc_ena) ena_cnt++;
         if (bus.done) begin
            got = 1;
            break;
         end
         if (lat == clr_loop_at) bus.loop_en = 1'b0;
         if (lat == wr_at) begin
            bus.wr_en    = 1'b1;
            bus.wr_addr  = '0;
            bus.wr_pitch = 8'd99;
            bus.wr_dur   = '0;
            bus.wr_rest  = 1'b0;
         end
      end
      bus.wr_en = 1'b0;
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected done", max);
         lat = -1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ena"}, int'(bus.osc_ena), 0);
      check({tag, "_pitch"}, int'(bus.osc_pitch_ticks), 0);
      check({tag, "_osc_rst"}, int'(bus.osc_rst), 0);
      check({tag, "_step"}, int'(bus.step_idx), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
   endtask

   initial begin
      vec_t vecs[8];
      int lat, ena, n0, seen;

      vecs[0] = '{5,   0, 0, 0, 2, 1};
      vecs[1] = '{7,   2, 0, 1, 7, 6};
      vecs[2] = '{200, 1, 1, 2, 7, 0};
      vecs[3] = '{255, 3, 0, 0, 5, 4};
      vecs[4] = '{1,   0, 0, 4, 6, 5};
      for (int i = 5; i < 8; i++) begin
         vecs[i].pitch   = int'($urandom_range(0, 255));
         vecs[i].dur     = int'($urandom_range(0, 3));
         vecs[i].rest    = int'($urandom_range(0, 1));
         vecs[i].tempo   = int'($urandom_range(0, 5));
         vecs[i].exp_lat = (vecs[i].dur + 1) * (vecs[i].tempo + 1) + 1;
         vecs[i].exp_ena = vecs[i].rest != 0 ? 0 : vecs[i].exp_lat - 1;
      end

      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_pitch = '0; bus.wr_dur = '0;
      bus.wr_rest = 1'b0; bus.tempo_ticks = '0; bus.last_step = '0; bus.loop_en = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Untouched table entry after reset is a silent, pitch-0, one-beat step.
      push_note(0, 0, 1);
      pulse_start();
      wait_done(20, 0, 0, lat, ena);
      check("rst_table_lat", lat, 2);
      check("rst_table_ena", ena, 0);

      for (int i = 0; i < 8; i++) begin
         wr(0, vecs[i].pitch, vecs[i].dur, vecs[i].rest);
         bus.tempo_ticks = TEMPO_W'(vecs[i].tempo);
         push_note(0, vecs[i].pitch, vecs[i].rest);
         pulse_start();
         wait_done(40, 0, 0, lat, ena);
         check("vec_lat", lat, vecs[i].exp_lat);
         check("vec_ena_cycles", ena, vecs[i].exp_ena);
         check("vec_busy_end", int'(bus.busy), 0);
      end

      // Three one-beat notes at tempo 3.
      wr(0, 10, 0, 0);
      wr(1, 20, 0, 0);
      wr(2, 30, 0, 0);
      bus.tempo_ticks = 16'd3;
      bus.last_step = AW'(2);
      push_note(0, 10, 0); push_note(1, 20, 0); push_note(2, 30, 0);
      n0 = n_notes;
      pulse_start();
      wait_done(40, 0, 0, lat, ena);
      check("seq3_lat", lat, 15);
      check("seq3_ena_cycles", ena, 12);
      check("seq3_busy", int'(bus.busy), 0);
      check("seq3_note_count", n_notes - n0, 3);
      @(posedge clk); #1;
      check("seq3_done_single", int'(bus.done), 0);

      // Rest in the middle.
      wr(1, 20, 0, 1);
      push_note(0, 10, 0); push_note(1, 20, 1); push_note(2, 30, 0);
      pulse_start();
      wait_done(40, 0, 0, lat, ena);
      check("rest_lat", lat, 15);
      check("rest_ena_cycles", ena, 8);

      // Loop 0,1,0,1 with a live write to step 0 and loop_en cleared mid-run.
      wr(1, 20, 0, 0);
      bus.last_step = AW'(1);
      bus.loop_en = 1'b1;
      push_note(0, 10, 0); push_note(1, 20, 0); push_note(0, 99, 0); push_note(1, 20, 0);
      pulse_start();
      wait_done(60, 12, 2, lat, ena);
      check("loop_lat", lat, 20);
      check("loop_ena_cycles", ena, 16);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      check("loop_extra_done", seen, 0);
      wr(0, 10, 0, 0);

      // Stop during step 1.
      bus.last_step = AW'(2);
      bus.loop_en = 1'b0;
      push_note(0, 10, 0); push_note(1, 20, 0);
      pulse_start();
      repeat (7) begin
         @(posedge clk); #1;
      end
      bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0;
      check("stop_busy", int'(bus.busy), 0);
      check("stop_ena", int'(bus.osc_ena), 0);
      check("stop_done", int'(bus.done), 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) seen++;
      end
      check("stop_quiet", seen, 0);

      // start and stop together in IDLE.
      @(negedge clk);
      bus.start = 1'b1;
      bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      check("startstop_busy0", int'(bus.busy), 0);
      @(posedge clk); #1;
      check("startstop_busy1", int'(bus.busy), 0);

      // rst in the middle of a note.
      bus.last_step = '0;
      push_note(0, 10, 0);
      pulse_start();
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("midrst_playing", int'(bus.osc_ena), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      rst = 1'b0;

      push_note(0, 0, 1);
      bus.tempo_ticks = '0;
      pulse_start();
      wait_done(20, 0, 0, lat, ena);
      check("post_rst_lat", lat, 2);
      check("post_rst_ena", ena, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
